// File: rtl/matrix_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader_pkg
//  Description : Shared definitions for the 2x2 matrix ALU operand loader:
//                controller state encoding, operation select codes and the
//                element-slot to bit-range mapping of a packed matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_operand_loader_pkg;

    // Controller state encoding (3 bits wide)
    typedef logic [2:0] state_t;
    localparam state_t LOAD_A  = 3'd0;
    localparam state_t LOAD_B  = 3'd1;
    localparam state_t WAIT_OP = 3'd2;
    localparam state_t EXEC    = 3'd3;
    localparam state_t DONE    = 3'd4;

    // Operation select presented to the ALU
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // A packed matrix holds four elements; slot 0 (a00) is the most
    // significant element and slot 3 (a11) the least significant one.
    localparam int c_slots = 4;

    // Least significant bit of the given slot inside a packed matrix.
    function automatic int slot_lsb(input logic [1:0] idx, input int elem_w);
        return (c_slots - 1 - int'(idx)) * elem_w;
    endfunction

endpackage : matrix_operand_loader_pkg
`default_nettype wire

// File: rtl/matrix_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader_if
//  Description : Bundle between the operand loader and its environment.
//                master : user-input path, ALU result return, display stage
//                slave  : the operand loader itself
//  Signals     : in_valid/in_data/in_op/start/clear  user-input strobes
//                alu_c                                 ALU combinational result
//                mat_a/mat_b/alu_op                    ALU operands
//                result/result_valid                   captured result
//                elem_idx/load_b/busy                  status for display
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_operand_loader_if #(
    parameter int ELEM_W = 8
);
    logic                  in_valid;
    logic [ELEM_W-1:0]     in_data;
    logic                  in_op;
    logic                  start;
    logic                  clear;
    logic [4*ELEM_W-1:0]   alu_c;
    logic [4*ELEM_W-1:0]   mat_a;
    logic [4*ELEM_W-1:0]   mat_b;
    logic                  alu_op;
    logic [4*ELEM_W-1:0]   result;
    logic                  result_valid;
    logic [1:0]            elem_idx;
    logic                  load_b;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_op, start, clear, alu_c,
        input  mat_a, mat_b, alu_op, result, result_valid, elem_idx, load_b, busy
    );

    modport slave (
        input  in_valid, in_data, in_op, start, clear, alu_c,
        output mat_a, mat_b, alu_op, result, result_valid, elem_idx, load_b, busy
    );

endinterface : matrix_operand_loader_if
`default_nettype wire

// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader
//  Description : Sequential front end of the 2x2 matrix ALU. Collects the
//                eight elements of A and B serially, latches the operation
//                on start, holds the operands steady for one EXEC cycle and
//                registers the ALU result with a valid flag. With CHAIN_EN
//                set, a start in DONE feeds the result back as the next A.
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                bus    matrix_operand_loader_if.slave (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter bit CHAIN_EN = 1'b0
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    matrix_operand_loader_if.slave       bus
);

    localparam int c_mat_w = 4 * ELEM_W;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_elem_idx;
    logic [c_mat_w-1:0]   r_mat_a;
    logic [c_mat_w-1:0]   r_mat_b;
    logic [c_mat_w-1:0]   r_result;
    logic                 r_alu_op;
    logic                 r_result_valid;
    logic                 w_busy;
    logic                 w_load_b;

    // Accepted-action strobes. clear outranks everything; in DONE a chain
    // start outranks an element arriving in the same cycle.
    logic w_wr_a;
    logic w_wr_b;
    logic w_op_latch;
    logic w_capture;
    logic w_chain;
    logic w_reload;

    assign w_wr_a     = !bus.clear && (r_state == LOAD_A)  && bus.in_valid;
    assign w_wr_b     = !bus.clear && (r_state == LOAD_B)  && bus.in_valid;
    assign w_op_latch = !bus.clear && (r_state == WAIT_OP) && bus.start;
    assign w_capture  = !bus.clear && (r_state == EXEC);
    assign w_chain    = !bus.clear && (r_state == DONE) && bus.start && CHAIN_EN;
    assign w_reload   = !bus.clear && (r_state == DONE) && bus.in_valid && !w_chain;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (bus.clear) begin
            w_next_state = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (bus.in_valid && (r_elem_idx == 2'd3)) begin
                        w_next_state = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid && (r_elem_idx == 2'd3)) begin
                        w_next_state = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (bus.start) begin
                        w_next_state = EXEC;
                    end
                end
                EXEC: begin
                    w_next_state = DONE;
                end
                DONE: begin
                    if (w_chain) begin
                        w_next_state = LOAD_B;
                    end else if (bus.in_valid) begin
                        w_next_state = LOAD_A;
                    end
                end
                default: begin
                    w_next_state = LOAD_A;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy   = 1'b0;
        w_load_b = 1'b0;
        case (r_state)
            EXEC:    w_busy   = 1'b1;
            LOAD_B:  w_load_b = 1'b1;
            default: begin
                w_busy   = 1'b0;
                w_load_b = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, op and result registers. The matrices only change on an
    // accepted load or chain, so the ALU inputs stay quiet through EXEC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elem_idx     <= 2'd0;
            r_mat_a        <= '0;
            r_mat_b        <= '0;
            r_result       <= '0;
            r_alu_op       <= OP_MUL;
            r_result_valid <= 1'b0;
        end else begin
            if (bus.clear) begin
                r_elem_idx     <= 2'd0;
                r_result_valid <= 1'b0;
            end
            if (w_wr_a) begin
                r_mat_a[slot_lsb(r_elem_idx, ELEM_W) +: ELEM_W] <= bus.in_data;
                r_elem_idx <= r_elem_idx + 2'd1;   // wraps 3 -> 0 into LOAD_B
            end
            if (w_wr_b) begin
                r_mat_b[slot_lsb(r_elem_idx, ELEM_W) +: ELEM_W] <= bus.in_data;
                r_elem_idx <= r_elem_idx + 2'd1;   // wraps 3 -> 0 into WAIT_OP
            end
            if (w_op_latch) begin
                r_alu_op <= bus.in_op;
            end
            if (w_capture) begin
                r_result       <= bus.alu_c;
                r_result_valid <= 1'b1;
            end
            if (w_chain) begin
                r_mat_a        <= r_result;
                r_elem_idx     <= 2'd0;
                r_result_valid <= 1'b0;
            end
            // A new element in DONE starts a fresh A; old B is kept until
            // it is overwritten by later loads.
            if (w_reload) begin
                r_mat_a[slot_lsb(2'd0, ELEM_W) +: ELEM_W] <= bus.in_data;
                r_elem_idx     <= 2'd1;
                r_result_valid <= 1'b0;
            end
        end
    end

    assign bus.mat_a        = r_mat_a;
    assign bus.mat_b        = r_mat_b;
    assign bus.alu_op       = r_alu_op;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.elem_idx     = r_elem_idx;
    assign bus.load_b       = w_load_b;
    assign bus.busy         = w_busy;

endmodule : matrix_operand_loader
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_operand_loader
//  Description : Self-checking bench. Two loaders (chaining off / on) share
//                one stimulus stream; each has a behavioural 2x2 ALU beside
//                it and a reference model that tracks the element count and
//                operand arrays directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_op;
    logic       s_start;
    logic       s_clear;

    int n_total = 0;
    int n_bad   = 0;

    matrix_operand_loader_if #(.ELEM_W(8)) bus0 ();
    matrix_operand_loader_if #(.ELEM_W(8)) bus1 ();

    matrix_operand_loader #(.ELEM_W(8), .CHAIN_EN(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    matrix_operand_loader #(.ELEM_W(8), .CHAIN_EN(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2x2 matrix ALU: element (i,j) sits at bits (3-(2i+j))*8, modulo 256.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        logic [7:0]  x [2][2];
        logic [7:0]  y [2][2];
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                x[i][j] = a[(3 - (2 * i + j)) * 8 +: 8];
                y[i][j] = b[(3 - (2 * i + j)) * 8 +: 8];
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (op)
                    c[(3 - (2 * i + j)) * 8 +: 8] = x[i][j] + y[i][j];
                else
                    c[(3 - (2 * i + j)) * 8 +: 8] = x[i][0] * y[0][j] + x[i][1] * y[1][j];
            end
        return c;
    endfunction

    assign bus0.in_valid = s_valid;
    assign bus0.in_data  = s_data;
    assign bus0.in_op    = s_op;
    assign bus0.start    = s_start;
    assign bus0.clear    = s_clear;
    assign bus0.alu_c    = alu_fn(bus0.mat_a, bus0.mat_b, bus0.alu_op);
    assign bus1.in_valid = s_valid;
    assign bus1.in_data  = s_data;
    assign bus1.in_op    = s_op;
    assign bus1.start    = s_start;
    assign bus1.clear    = s_clear;
    assign bus1.alu_c    = alu_fn(bus1.mat_a, bus1.mat_b, bus1.alu_op);

    // Reference model: cnt counts loaded elements (0-3 A, 4-7 B, 8 = all
    // loaded). Slot k of a packed matrix is element [3-k] of the array.
    typedef struct packed {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [31:0]     res;
        logic            op;
        logic [3:0]      cnt;
        logic            exec;
        logic            done;
        logic            rv;
    } model_t;

    model_t m [2];

    function automatic model_t model_step(input model_t s, input bit chain, input logic v,
                                          input logic [7:0] d, input logic op,
                                          input logic st, input logic cl);
        model_t n;
        n = s;
        if (cl) begin
            n.cnt = 0; n.exec = 0; n.done = 0; n.rv = 0;
        end else if (s.exec) begin
            n.res = alu_fn(s.a, s.b, s.op); n.rv = 1; n.exec = 0; n.done = 1;
        end else if (s.done) begin
            if (st && chain) begin
                n.a = s.res; n.rv = 0; n.done = 0; n.cnt = 4;
            end else if (v) begin
                n.a[3] = d; n.rv = 0; n.done = 0; n.cnt = 1;
            end
        end else if (s.cnt == 8) begin
            if (st) begin
                n.op = op; n.exec = 1;
            end
        end else if (v) begin
            if (s.cnt < 4) n.a[3 - int'(s.cnt)] = d;
            else           n.b[7 - int'(s.cnt)] = d;
            n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_one(input int k, input model_t e, input logic [31:0] ma,
                             input logic [31:0] mb, input logic op, input logic [31:0] res,
                             input logic rv, input logic [1:0] idx, input logic lb,
                             input logic bs);
        cmp($sformatf("dut%0d.mat_a", k),        ma,  e.a);
        cmp($sformatf("dut%0d.mat_b", k),        mb,  e.b);
        cmp($sformatf("dut%0d.alu_op", k),       32'(op),  32'(e.op));
        cmp($sformatf("dut%0d.result", k),       res, e.res);
        cmp($sformatf("dut%0d.result_valid", k), 32'(rv),  32'(e.rv));
        cmp($sformatf("dut%0d.elem_idx", k),     32'(idx), 32'(e.cnt[1:0]));
        cmp($sformatf("dut%0d.load_b", k),       32'(lb),
            32'(!e.exec && !e.done && e.cnt >= 4 && e.cnt < 8));
        cmp($sformatf("dut%0d.busy", k),         32'(bs),  32'(e.exec));
    endtask

    task automatic check_all();
        check_one(0, m[0], bus0.mat_a, bus0.mat_b, bus0.alu_op, bus0.result,
                  bus0.result_valid, bus0.elem_idx, bus0.load_b, bus0.busy);
        check_one(1, m[1], bus1.mat_a, bus1.mat_b, bus1.alu_op, bus1.result,
                  bus1.result_valid, bus1.elem_idx, bus1.load_b, bus1.busy);
    endtask

    // One clock: drive on the falling edge, advance the models on the
    // rising edge, compare 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic op,
                        input logic st, input logic cl);
        @(negedge clk);
        s_valid = v; s_data = d; s_op = op; s_start = st; s_clear = cl;
        @(posedge clk);
        m[0] = model_step(m[0], 1'b0, v, d, op, st, cl);
        m[1] = model_step(m[1], 1'b1, v, d, op, st, cl);
        #1;
        check_all();
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) step(1'b1, w[31 - 8 * i -: 8], 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst_n = 1'b0; s_valid = 0; s_data = 0; s_op = 0; s_start = 0; s_clear = 0;
        m[0] = '0; m[1] = '0;

        vecs[0] = '{32'h01020304, 32'h05060708, 1'b0, 32'h13162B32};
        vecs[1] = '{32'h01020304, 32'h05060708, 1'b1, 32'h06080A0C};
        vecs[2] = '{32'h10101010, 32'h10101010, 1'b0, 32'h00000000};
        vecs[3] = '{32'h80808080, 32'h80808080, 1'b1, 32'h00000000};
        vecs[4] = '{32'h02030405, 32'h01000001, 1'b0, 32'h02030405};

        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        cmp("reset.elem_idx", 32'(bus0.elem_idx), 32'd0);
        rst_n = 1'b1;

        // Table-driven operand sets
        for (int t = 0; t < 5; t++) begin
            load_word(vecs[t].a);
            load_word(vecs[t].b);
            cmp($sformatf("vec%0d.mat_a", t), bus0.mat_a, vecs[t].a);
            cmp($sformatf("vec%0d.mat_b", t), bus0.mat_b, vecs[t].b);
            step(1'b0, 8'h00, vecs[t].op, 1'b1, 1'b0);       // start edge
            cmp($sformatf("vec%0d.busy_exec", t), 32'(bus0.busy), 32'd1);
            cmp($sformatf("vec%0d.rv_early", t), 32'(bus0.result_valid), 32'd0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);             // second edge
            cmp($sformatf("vec%0d.busy_after", t), 32'(bus0.busy), 32'd0);
            cmp($sformatf("vec%0d.rv", t), 32'(bus0.result_valid), 32'd1);
            cmp($sformatf("vec%0d.result", t), bus0.result, vecs[t].exp);
            cmp($sformatf("vec%0d.alu_op", t), 32'(bus0.alu_op), 32'(vecs[t].op));
        end

        // Ignore rules and clear
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);                 // start in LOAD_A
        cmp("ign.start_loada_idx", 32'(bus0.elem_idx), 32'd2);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);                 // start in LOAD_B
        cmp("ign.start_loadb_busy", 32'(bus0.busy), 32'd0);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);                 // six elements
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);                 // clear
        cmp("clear.elem_idx", 32'(bus0.elem_idx), 32'd0);
        cmp("clear.load_b", 32'(bus0.load_b), 32'd0);
        load_word(32'hA1A2A3A4);
        load_word(32'hB1B2B3B4);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);                 // in_valid in WAIT_OP
        cmp("ign.valid_wait_b", bus0.mat_b, 32'hB1B2B3B4);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);                 // clear + start
        cmp("clear_start.busy", 32'(bus0.busy), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cmp("clear_start.rv", 32'(bus0.result_valid), 32'd0);

        // Chaining
        load_word(32'h01020304);
        load_word(32'h05060708);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cmp("chain.first_result", bus1.result, 32'h13162B32);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);                 // start + element in DONE
        cmp("chain.mat_a", bus1.mat_a, 32'h13162B32);
        cmp("chain.load_b", 32'(bus1.load_b), 32'd1);
        cmp("chain.elem_idx", 32'(bus1.elem_idx), 32'd0);
        cmp("nochain.reload_a0", 32'(bus0.mat_a[31:24]), 32'h99);
        load_word(32'h01000001);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cmp("chain.identity_result", bus1.result, 32'h13162B32);
        cmp("chain.identity_rv", 32'(bus1.result_valid), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset in the middle of EXEC
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        load_word(32'h01020304);
        load_word(32'h05060708);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cmp("areset.in_exec", 32'(bus0.busy), 32'd1);
        #1;
        s_valid = 0; s_data = 0; s_op = 0; s_start = 0; s_clear = 0;
        rst_n = 1'b0;
        #1;
        m[0] = '0; m[1] = '0;
        cmp("areset.mat_a", bus1.mat_a, 32'h0);
        cmp("areset.busy", 32'(bus0.busy), 32'd0);
        cmp("areset.result_valid", 32'(bus1.result_valid), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        cmp("areset.reload_a", bus0.mat_a, 32'hAB000000);
        cmp("areset.idx", 32'(bus0.elem_idx), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_matrix_operand_loader
`default_nettype wire

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Sequential front end for the 2x2 matrix ALU.
- Collects eight 8-bit elements serially (matrix A, then matrix B) from the user-input path and latches the operation select.
- Drives the ALU's packed A/B/op inputs, captures the ALU's combinational result into a register, and presents it with a valid flag to the display stage.
- Optional chaining reuses the previous result as the next A operand.

Parameters:
- ELEM_W, 8, element width; the packed matrix is 4*ELEM_W bits; only 8 is supported by the ALU.
- CHAIN_EN, 0, when 1, a start pulse in DONE loads result into A and jumps to LOAD_B.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle strobe; in_data is an element to load
- in_data  input  8  element value
- in_op  input  1  operation select sampled on start; 0 = multiply, 1 = add
- start  input  1  one-cycle strobe requesting execution
- clear  input  1  synchronous abort and return to LOAD_A
- alu_c  input  32  combinational result returned from the ALU
- mat_a  output  32  packed A to the ALU: [31:24]=a00, [23:16]=a01, [15:8]=a10, [7:0]=a11
- mat_b  output  32  packed B to the ALU, same packing
- alu_op  output  1  registered op to the ALU
- result  output  32  captured ALU result
- result_valid  output  1  high while result holds a fresh value
- elem_idx  output  2  index of the next element slot, for display
- load_b  output  1  0 = filling A, 1 = filling B
- busy  output  1  high in EXEC

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state LOAD_A, elem_idx 0. Reset mid-load or mid-EXEC discards everything.
- States: LOAD_A, LOAD_B, WAIT_OP, EXEC, DONE.
- LOAD_A: each in_valid writes in_data into the mat_a slot selected by elem_idx (0 goes to [31:24], 3 goes to [7:0]) and increments elem_idx. The write with elem_idx=3 wraps elem_idx to 0 and moves to LOAD_B. start is ignored.
- LOAD_B: same as LOAD_A, writing mat_b. The fourth element moves to WAIT_OP. start is ignored.
- WAIT_OP: start latches in_op into alu_op and moves to EXEC. in_valid is ignored.
- EXEC: lasts exactly 1 cycle; busy=1. mat_a, mat_b and alu_op are stable. At the end of the cycle, alu_c is registered into result, result_valid is set, and the state moves to DONE.
  - Latency: 2 rising edges from the start edge to result_valid=1.
- DONE: result_valid=1 and result is held.
  - in_valid: result_valid clears, the element goes to mat_a slot 0, elem_idx becomes 1, and the state moves to LOAD_A. The previous mat_b is retained until it is overwritten.
  - start with CHAIN_EN=1: mat_a<=result, result_valid clears, elem_idx=0, and the state moves to LOAD_B.
  - start with CHAIN_EN=0: ignored.
- clear (any state): synchronous. Goes to LOAD_A, elem_idx=0, result_valid=0. mat_a, mat_b and result are not zeroed.
- Priority within a cycle: clear > start > in_valid.
  - In DONE, a simultaneous start and in_valid with CHAIN_EN=1 takes the chain path and drops the element.
- Arithmetic belongs to the ALU: 8-bit per element, modulo 256, no saturation. This block performs no arithmetic beyond the 2-bit elem_idx increment.
- mat_a and mat_b change only on accepted loads, so the ALU inputs are glitch-free during EXEC.

Decomposition:
- Shared package holds:
  - state encoding constants: LOAD_A=0, LOAD_B=1, WAIT_OP=2, EXEC=3, DONE=4 (3 bits)
  - OP_MUL=0 and OP_ADD=1
  - slot-to-bit-range helper constants
- No sub-module required. The ALU is instantiated beside this block at the top level, not inside it.

Test Plan:
- Load A=1,2,3,4 and B=5,6,7,8, then start with in_op=0. Required: mat_a=0x01020304, mat_b=0x05060708, alu_op=0, result=0x13162B32, result_valid=1 two edges after start, busy high for exactly 1 cycle.
- Same operands with in_op=1. Required: result=0x06080A0C.
- Overflow: A and B all 0x10, multiply. Required: result=0x00000000. A and B all 0x80, add. Required: result=0x00000000.
- Ignore rules and clear: start during LOAD_A/LOAD_B and in_valid during WAIT_OP change nothing. clear after 6 elements returns to LOAD_A with elem_idx=0. clear together with start in WAIT_OP leaves EXEC unentered.
- Chaining with CHAIN_EN=1: after result 0x13162B32, start enters LOAD_B with mat_a=0x13162B32. Then load B=1,0,0,1 (identity) and multiply. Required: result=0x13162B32.
- Asynchronous reset: assert rst_n low mid-EXEC, between clock edges. Required: all outputs 0 immediately and state LOAD_A after release.
